// File: rtl/riscv_pkg.sv
// Shared types and helpers for the EX operand forwarding controller.
// Holds mux select codes, the stage tag bundle and tag match helpers.
package riscv_pkg;

    localparam int REGW_DEF = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [REGW_DEF-1:0] rs1;
        logic [REGW_DEF-1:0] rs2;
        logic                use_rs1;
        logic                use_rs2;
        logic [REGW_DEF-1:0] rd;
        logic                regwrite;
        logic                memread;
    } stage_tag_t;

    // x0 is hardwired zero, so it never counts as a producer.
    function automatic logic writes_reg(
        input stage_tag_t          t,
        input logic [REGW_DEF-1:0] r
    );
        return t.valid & t.regwrite
             & (t.rd == r) & (r != '0);
    endfunction

    // MEM is checked first: it holds the younger value.
    function automatic logic [1:0] fwd_sel(
        input logic                used,
        input logic [REGW_DEF-1:0] rs,
        input stage_tag_t          mem,
        input stage_tag_t          wb
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (used) begin
            if (writes_reg(mem, rs))
                sel = FWD_MEM;
            else if (writes_reg(wb, rs))
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline tag slot with async active-low clear and bubble insert.
// Ports: clk, rst_n, bubble (load invalid tag), d (next tag), q (slot).
module stage_tag_reg
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble,
    input  stage_tag_t d,
    output stage_tag_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (bubble)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Forwarding select and load-use stall control for the EX operand muxes.
// Ports: ID tag inputs, ex_flush; fwd_a_sel/fwd_b_sel, stall, stall_cnt.
module operand_forward_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = REGW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            ex_flush,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            stall,
    output logic [XLEN-1:0] stall_cnt
);

    stage_tag_t id_tag;
    stage_tag_t ex_q;
    stage_tag_t mem_q;
    stage_tag_t wb_q;
    logic       ex_bubble;
    logic       hazard;
    logic       dep_rs1;
    logic       dep_rs2;

    always_comb begin
        id_tag          = '0;
        id_tag.valid    = id_valid;
        id_tag.rs1      = id_rs1;
        id_tag.rs2      = id_rs2;
        id_tag.use_rs1  = id_use_rs1;
        id_tag.use_rs2  = id_use_rs2;
        id_tag.rd       = id_rd;
        id_tag.regwrite = id_regwrite;
        id_tag.memread  = id_memread;
    end

    assign ex_bubble = ~id_valid | stall | ex_flush;

    stage_tag_reg u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (ex_bubble),
        .d      (id_tag),
        .q      (ex_q)
    );

    stage_tag_reg u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    stage_tag_reg u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    assign fwd_a_sel = fwd_sel(
        ex_q.valid & ex_q.use_rs1,
        ex_q.rs1, mem_q, wb_q);

    assign fwd_b_sel = fwd_sel(
        ex_q.valid & ex_q.use_rs2,
        ex_q.rs2, mem_q, wb_q);

    assign dep_rs1 = id_use_rs1 & (id_rs1 == ex_q.rd);
    assign dep_rs2 = id_use_rs2 & (id_rs2 == ex_q.rd);

    assign hazard = id_valid
                  & ex_q.valid
                  & ex_q.memread
                  & (ex_q.rd != '0)
                  & (dep_rs1 | dep_rs2);

    // A squashed instruction must not hold the front end.
    assign stall = hazard & ~ex_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
